// File: rtl/icb_wdt.sv
// rtl/icb_wdt.sv - ICB watchdog timer: keyed feed, timeout interrupt, multi-cycle reset request
// Optional WDT_WINDOW_EN: adds WIN register at 0x14; key-valid feeds while CNT > WIN are rejected and trigger reset.

module icb_wdt #(
  parameter int unsigned CNT_W         = 32,
  parameter logic [31:0] FEED_KEY      = 32'h5A5A_A5A5,
  parameter int unsigned RST_PULSE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wdt_icb_cmd_valid,
  output logic        wdt_icb_cmd_ready,
  input  logic [31:0] wdt_icb_cmd_addr,
  input  logic        wdt_icb_cmd_read,
  input  logic [31:0] wdt_icb_cmd_wdata,
  input  logic [3:0]  wdt_icb_cmd_wmask,
  output logic        wdt_icb_rsp_valid,
  input  logic        wdt_icb_rsp_ready,
  output logic        wdt_icb_rsp_err,
  output logic [31:0] wdt_icb_rsp_rdata,
  output logic        wdt_irq,
  output logic        wdt_rst_req
);

  localparam int unsigned PW = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_LOAD = 3'd1;
  localparam logic [2:0] OFF_CNT  = 3'd2;
  localparam logic [2:0] OFF_FEED = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;
  localparam logic [2:0] OFF_WIN  = 3'd5;

  logic [2:0]       ctrl_q;
  logic [CNT_W-1:0] load_q;
  logic [CNT_W-1:0] cnt_q;
  logic             en_prev_q;
  logic             to_q;
  logic             rstf_q;
  logic             rst_req_q;
  logic [PW-1:0]    pulse_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;
`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] win_q;
  logic             win_we;
`endif

  logic        accept;
  logic [2:0]  off;
  logic        key_ok;
  logic        rsp_err_d;
  logic [31:0] rsp_rdata_d;
  logic        ctrl_we;
  logic        load_we;
  logic        stat_we;
  logic        feed_ok;
  logic        early_feed;
  logic        en_rise;
  logic        expire;
  logic        rst_fire;
  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  assign accept      = wdt_icb_cmd_valid & ~rsp_valid_q;
  assign off         = wdt_icb_cmd_addr[4:2];
  assign key_ok      = (wdt_icb_cmd_wmask == 4'hF) && (wdt_icb_cmd_wdata == FEED_KEY);
  assign unused_addr = ^{wdt_icb_cmd_addr[31:5], wdt_icb_cmd_addr[1:0]};

  always_comb begin
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    ctrl_we     = 1'b0;
    load_we     = 1'b0;
    stat_we     = 1'b0;
    feed_ok     = 1'b0;
    early_feed  = 1'b0;
`ifdef WDT_WINDOW_EN
    win_we      = 1'b0;
`endif
    if (accept) begin
      case (off)
        OFF_CTRL: begin
          if (wdt_icb_cmd_read) rsp_rdata_d = 32'(ctrl_q);
          else if (ctrl_q[2])   rsp_err_d   = 1'b1;
          else                  ctrl_we     = 1'b1;
        end
        OFF_LOAD: begin
          if (wdt_icb_cmd_read) rsp_rdata_d = 32'(load_q);
          else if (ctrl_q[2])   rsp_err_d   = 1'b1;
          else                  load_we     = 1'b1;
        end
        OFF_CNT: begin
          if (wdt_icb_cmd_read) rsp_rdata_d = 32'(cnt_q);
          else                  rsp_err_d   = 1'b1;
        end
        OFF_FEED: begin
          if (!wdt_icb_cmd_read) begin
            if (!key_ok) rsp_err_d = 1'b1;
`ifdef WDT_WINDOW_EN
            else if (cnt_q > win_q) begin
              rsp_err_d  = 1'b1;
              early_feed = 1'b1;
            end
`endif
            else feed_ok = 1'b1;
          end
        end
        OFF_STAT: begin
          if (wdt_icb_cmd_read) rsp_rdata_d = {30'd0, rstf_q, to_q};
          else                  stat_we     = 1'b1;
        end
`ifdef WDT_WINDOW_EN
        OFF_WIN: begin
          if (wdt_icb_cmd_read) rsp_rdata_d = 32'(win_q);
          else if (ctrl_q[2])   rsp_err_d   = 1'b1;
          else                  win_we      = 1'b1;
        end
`endif
        default: rsp_err_d = 1'b1;
      endcase
    end
  end

  // A feed in the same cycle as expiry takes priority; the EN rising edge reload masks a stale CNT of 0.
  assign en_rise  = ctrl_q[0] & ~en_prev_q;
  assign expire   = ctrl_q[0] & ~en_rise & ~feed_ok & (cnt_q == '0);
  assign rst_fire = (expire & to_q) | early_feed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      load_q      <= '1;
      cnt_q       <= '0;
      en_prev_q   <= 1'b0;
      to_q        <= 1'b0;
      rstf_q      <= 1'b0;
      rst_req_q   <= 1'b0;
      pulse_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef WDT_WINDOW_EN
      win_q       <= '1;
`endif
    end else begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= rsp_err_d;
        rsp_rdata_q <= rsp_rdata_d;
      end else if (wdt_icb_rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      if (ctrl_we && wdt_icb_cmd_wmask[0])
        ctrl_q <= {ctrl_q[2] | wdt_icb_cmd_wdata[2], wdt_icb_cmd_wdata[1:0]};
      if (load_we)
        load_q <= CNT_W'(merge(32'(load_q), wdt_icb_cmd_wdata, wdt_icb_cmd_wmask));
`ifdef WDT_WINDOW_EN
      if (win_we)
        win_q <= CNT_W'(merge(32'(win_q), wdt_icb_cmd_wdata, wdt_icb_cmd_wmask));
`endif
      en_prev_q <= ctrl_q[0];

      if (en_rise || feed_ok || expire) cnt_q <= load_q;
      else if (ctrl_q[0] && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);

      // Set beats a simultaneous write-1-to-clear.
      to_q   <= (expire & ~to_q) |
                (to_q & ~(stat_we & wdt_icb_cmd_wmask[0] & wdt_icb_cmd_wdata[0]));
      rstf_q <= rstf_q | rst_fire;

      if (rst_fire && !rst_req_q) begin
        rst_req_q <= 1'b1;
        pulse_q   <= PW'(RST_PULSE_CYC - 1);
      end else if (rst_req_q) begin
        if (pulse_q == '0) rst_req_q <= 1'b0;
        else               pulse_q   <= pulse_q - PW'(1);
      end
    end
  end

  assign wdt_icb_cmd_ready = ~rsp_valid_q;
  assign wdt_icb_rsp_valid = rsp_valid_q;
  assign wdt_icb_rsp_err   = rsp_err_q;
  assign wdt_icb_rsp_rdata = rsp_rdata_q;
  assign wdt_irq           = to_q & ctrl_q[1];
  assign wdt_rst_req       = rst_req_q;

endmodule

// File: tb/tb_icb_wdt.sv
// tb/tb_icb_wdt.sv - table-driven register checks plus timed sequences for icb_wdt
// Window checks are compiled in when WDT_WINDOW_EN is defined.

module tb_icb_wdt;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
`ifdef WDT_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        irq;
  logic        rst_req;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icb_wdt dut (
    .clk               (clk),
    .rst               (rst),
    .wdt_icb_cmd_valid (cmd_valid),
    .wdt_icb_cmd_ready (cmd_ready),
    .wdt_icb_cmd_addr  (cmd_addr),
    .wdt_icb_cmd_read  (cmd_read),
    .wdt_icb_cmd_wdata (cmd_wdata),
    .wdt_icb_cmd_wmask (cmd_wmask),
    .wdt_icb_rsp_valid (rsp_valid),
    .wdt_icb_rsp_ready (rsp_ready),
    .wdt_icb_rsp_err   (rsp_err),
    .wdt_icb_rsp_rdata (rsp_rdata),
    .wdt_irq           (irq),
    .wdt_rst_req       (rst_req)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive on a negedge; the accept edge is the following posedge; returns one negedge after the response.
  task automatic xact(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] wm, output logic [31:0] rdat, output logic err);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = wm;
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 8) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 8) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 at addr 0x%08h", addr);
    end
    rdat = rsp_rdata;
    err  = rsp_err;
    @(negedge clk);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] wm, input bit exp_err);
    logic [31:0] r; logic e;
    xact(1'b0, addr, wd, wm, r, e);
    chk({name, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic rdchk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e;
    xact(1'b1, addr, 32'd0, 4'h0, r, e);
    chk({name, "_rdata"}, r, exp);
    chk({name, "_err"}, {31'd0, e}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          c;

    vecs.push_back('{1'b1, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h04, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b1, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0C, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'h10, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h04, 32'h0, 4'h0, 32'h0000_0010, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'hAABB_CCDD, 4'b0100, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h04, 32'h0, 4'h0, 32'h00BB_0010, 1'b0});
    vecs.push_back('{1'b1, 32'h1000_0004, 32'h0, 4'h0, 32'h00BB_0010, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h5, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0C, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0C, KEY, 4'h7, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h18, 32'h0, 4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h14, 32'h0, 4'h0, WIN_EN ? 32'hFFFF_FFFF : 32'h0, !WIN_EN});
    vecs.push_back('{1'b0, 32'h1C, 32'h1, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h00, 32'h7, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 32'h3, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h0, 4'h0, 32'h0000_0003, 1'b0});
    vecs.push_back('{1'b1, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 1'b0});

    do_reset();
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_rst_req", {31'd0, rst_req}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      xact(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, r, e);
      chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
    end

    // Expiry: LOAD=5 reloads at P2; expiries at P8 and P14 after the CTRL accept edge P1.
    do_reset();
    wr("exp_load", 32'h04, 32'd5, 4'hF, 1'b0);
    wr("exp_ctrl", 32'h00, 32'h3, 4'hF, 1'b0);
    repeat (5) @(negedge clk);
    chk("exp_irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("exp_irq_first", {31'd0, irq}, 32'd1);
    repeat (5) @(negedge clk);
    chk("exp_rst_before", {31'd0, rst_req}, 32'd0);
    @(negedge clk);
    c = 0;
    while (rst_req && c < 40) begin c++; @(negedge clk); end
    chk("exp_rst_len", c, 32'd16);
    rdchk("exp_stat", 32'h10, 32'h3);

    // W1C in the same cycle as the first expiry: set wins.
    do_reset();
    wr("w1c_load", 32'h04, 32'd5, 4'hF, 1'b0);
    wr("w1c_ctrl", 32'h00, 32'h3, 4'hF, 1'b0);
    repeat (4) @(negedge clk);
    wr("w1c_race", 32'h10, 32'h1, 4'hF, 1'b0);
    chk("w1c_race_irq", {31'd0, irq}, 32'd1);
    wr("w1c_clr", 32'h10, 32'h1, 4'hF, 1'b0);
    chk("w1c_clr_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    chk("w1c_reexp_irq", {31'd0, irq}, 32'd1);
    chk("w1c_reexp_rst", {31'd0, rst_req}, 32'd0);

    // Feeding keeps the counter away from zero.
    do_reset();
    wr("feed_load", 32'h04, 32'd5, 4'hF, 1'b0);
    wr("feed_ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
    for (int i = 0; i < 25; i++) begin
      wr($sformatf("feed%0d", i), 32'h0C, KEY, 4'hF, 1'b0);
      @(negedge clk);
    end
    rdchk("feed_stat", 32'h10, 32'h0);
    wr("feed_dis", 32'h00, 32'h0, 4'hF, 1'b0);
    wr("feed_good", 32'h0C, KEY, 4'hF, 1'b0);
    wr("feed_bad", 32'h0C, 32'h1234_5678, 4'hF, 1'b1);
    rdchk("feed_cnt", 32'h08, 32'd5);

    // Lock.
    do_reset();
    wr("lock_set", 32'h00, 32'h5, 4'hF, 1'b0);
    wr("lock_ctrl", 32'h00, 32'h0, 4'hF, 1'b1);
    wr("lock_load", 32'h04, 32'h3, 4'hF, 1'b1);
    rdchk("lock_ctrl_rd", 32'h00, 32'h5);
    rdchk("lock_load_rd", 32'h04, 32'hFFFF_FFFF);
    wr("lock_stat", 32'h10, 32'h1, 4'hF, 1'b0);

    // LOAD=0: TO at P3, reset request at P4; clearing EN mid-pulse does not truncate it.
    do_reset();
    wr("zero_load", 32'h04, 32'd0, 4'hF, 1'b0);
    wr("zero_ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
    @(negedge clk);
    chk("zero_rst_first", {31'd0, rst_req}, 32'd0);
    @(negedge clk);
    chk("zero_rst_second", {31'd0, rst_req}, 32'd1);
    @(negedge clk);
    wr("zero_dis", 32'h00, 32'h0, 4'hF, 1'b0);
    c = 0;
    while (rst_req && c < 40) begin c++; @(negedge clk); end
    chk("zero_rst_rest", c, 32'd12);

    // Async reset aborts an active pulse and a pending response.
    wr("abort_ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
    @(negedge clk);
    chk("abort_pulse_on", {31'd0, rst_req}, 32'd1);
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h08; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_rsp_pending", {31'd0, rsp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst_req", {31'd0, rst_req}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    do_reset();

    // Backpressure on a CNT read.
    wr("bp_load", 32'h04, 32'h10, 4'hF, 1'b0);
    wr("bp_feed", 32'h0C, KEY, 4'hF, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h08; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_ready", i), {31'd0, cmd_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'h10);
      chk($sformatf("bp_hold%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h04;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_next_rdata", rsp_rdata, 32'h10);
    @(negedge clk);

`ifdef WDT_WINDOW_EN
    do_reset();
    wr("win_load", 32'h04, 32'd100, 4'hF, 1'b0);
    wr("win_win", 32'h14, 32'd20, 4'hF, 1'b0);
    wr("win_ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
    repeat (40) @(negedge clk);
    wr("win_early", 32'h0C, KEY, 4'hF, 1'b1);
    chk("win_early_rst", {31'd0, rst_req}, 32'd1);
    repeat (45) @(negedge clk);
    wr("win_ok", 32'h0C, KEY, 4'hF, 1'b0);
    rdchk("win_cnt", 32'h08, 32'd98);
    rdchk("win_stat", 32'h10, 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
